// File: rtl/if_stage_hs.sv
// Instruction-fetch stage with a req/ack handshake to variable-latency instruction memory.
// Handles stall, IF/ID flush and branch redirect, including while a fetch is still outstanding.
module if_stage_hs #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter int                     PC_STEP     = 4,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk_in,
    input  logic                   n_rst_in,
    input  logic [PC_WIDTH-1:0]    pc_branch_in,
    input  logic                   ctrl_pc_src_in,
    input  logic                   stall_in,
    input  logic                   flush_in,
    output logic                   imem_req_out,
    output logic [PC_WIDTH-1:0]    imem_addr_out,
    input  logic                   imem_ack_in,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_in,
    output logic [PC_WIDTH-1:0]    IFID_pc_out,
    output logic [INSTR_WIDTH-1:0] IFID_ir_out,
    output logic                   IFID_valid_out
);

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    redir_pc, redir_pc_d;
    logic [INSTR_WIDTH-1:0] hold_ir, hold_ir_d;

    logic                   avail;
    logic                   consume;
    logic [INSTR_WIDTH-1:0] word;
    logic [PC_WIDTH-1:0]    pc_next_seq;

    logic                   ifid_valid_p1;
    logic [INSTR_WIDTH-1:0] ifid_ir_p1;
    logic [PC_WIDTH-1:0]    ifid_pc_p1;

    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
        return pc + STEP;
    endfunction

    assign imem_req_out  = n_rst_in && (state != HOLD);
    assign imem_addr_out = pc_q;
    assign pc_next_seq   = pc_inc(pc_q);

    always_comb begin
        avail   = ((state == FETCH) && imem_ack_in) || (state == HOLD);
        word    = (state == HOLD) ? hold_ir : imem_rdata_in;
        consume = avail && !stall_in && !flush_in && !ctrl_pc_src_in;
    end

    // Next-state: redirect, drain completion, consume, buffer, stay
    always_comb begin
        state_d    = state;
        pc_d       = pc_q;
        redir_pc_d = redir_pc;
        hold_ir_d  = hold_ir;
        if (ctrl_pc_src_in) begin
            if ((state != HOLD) && !imem_ack_in) begin
                // Request still open: its address must stay put, so remember the target
                state_d    = DRAIN;
                redir_pc_d = pc_branch_in;
            end else begin
                state_d = FETCH;
                pc_d    = pc_branch_in;
            end
        end else if ((state == DRAIN) && imem_ack_in) begin
            state_d = FETCH;
            pc_d    = redir_pc;
        end else if (consume) begin
            state_d = FETCH;
            pc_d    = pc_next_seq;
        end else if (avail) begin
            state_d = HOLD;
            if (state == FETCH) begin
                hold_ir_d = imem_rdata_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state    <= FETCH;
            pc_q     <= RESET_PC;
            redir_pc <= RESET_PC;
            hold_ir  <= NOP_INSTR;
        end else begin
            state    <= state_d;
            pc_q     <= pc_d;
            redir_pc <= redir_pc_d;
            hold_ir  <= hold_ir_d;
        end
    end

    // IF/ID register: flush beats stall, stall holds, otherwise load or bubble
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            ifid_valid_p1 <= 1'b0;
            ifid_ir_p1    <= NOP_INSTR;
            ifid_pc_p1    <= '0;
        end else if (flush_in) begin
            ifid_valid_p1 <= 1'b0;
            ifid_ir_p1    <= NOP_INSTR;
            ifid_pc_p1    <= '0;
        end else if (stall_in) begin
            ifid_valid_p1 <= ifid_valid_p1;
            ifid_ir_p1    <= ifid_ir_p1;
            ifid_pc_p1    <= ifid_pc_p1;
        end else if (consume) begin
            ifid_valid_p1 <= 1'b1;
            ifid_ir_p1    <= word;
            ifid_pc_p1    <= pc_next_seq;
        end else begin
            ifid_valid_p1 <= 1'b0;
            ifid_ir_p1    <= NOP_INSTR;
            ifid_pc_p1    <= '0;
        end
    end

    assign IFID_valid_out = ifid_valid_p1;
    assign IFID_ir_out    = ifid_ir_p1;
    assign IFID_pc_out    = ifid_pc_p1;

endmodule
